fdiv16_seq: RTL and testbench
=============================

FDIV16_SEQ -- requirements
Module: fdiv16_seq

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset_n  input  1  reset, asynchronous and active-low.
REQ-003 x  input  16  fp16 dividend, sampled only on an accepted start.
REQ-004 y  input  16  fp16 divisor, sampled only on an accepted start.
REQ-005 start  input  1  request; accepted only when busy=0.
REQ-006 roundmode  input  2  00 rz, 01 rne, 10 rp (toward +inf), 11 rn (toward -inf); sampled with x/y.
REQ-007 busy  output  1  high from the edge after acceptance until done.
REQ-008 done  output  1  one-cycle pulse; result/flags valid.
REQ-009 result  output  16  fp16 quotient x/y; held until the next done.
REQ-010 flags  output  5  {nv, dz, of, uf, nx}; held with result.

Function
REQ-011 States SHALL be IDLE, ITER, ROUND, DONE.
- IDLE->ITER on start.
- ITER->ROUND after 13 iterations.
- ROUND->DONE.
- DONE->IDLE.
REQ-012 start in any state other than IDLE SHALL be ignored, with no effect on operands or the running operation.
REQ-013 Latency SHALL be fixed for all operands: done high exactly 15 rising edges after the accepting edge, including special cases.
REQ-014 busy SHALL be 1 in ITER and ROUND, and 0 in DONE and IDLE.
REQ-015 Unpacking on accept: sign = x[15]^y[15]; mantissas {1,frac}, 11 bits; exp field 0 SHALL be treated as zero (subnormal inputs flush to signed zero).
REQ-016 Division SHALL be restoring, with 12-bit remainder rem initialised to mx.
- Each ITER cycle: q bit = (rem >= my); if set, rem -= my; then rem <<= 1.
- Bits fill q[12] down to q[0].
REQ-017 Normalisation:
- If q[12]=1: frac = q[11:2], guard = q[1], sticky = q[0] | (rem != 0), biased exp = ex-ey+15.
- Else: frac = q[10:1], guard = q[0], sticky = (rem != 0), biased exp = ex-ey+14.
- Exponent arithmetic SHALL be signed, at least 7 bits wide.
REQ-018 Rounding increment (ROUND state):
- rz: never.
- rne: guard & (sticky | frac[0]).
- rp: ~sign & (guard | sticky).
- rn: sign & (guard | sticky).
- Mantissa carry-out SHALL increment the exponent and zero frac.
REQ-019 Overflow (rounded biased exp >= 31) SHALL set of and nx; the value depends on roundmode:
- rz: signed 0x7BFF.
- rne: signed infinity.
- rp: +inf if positive, else 0xFBFF.
- rn: -inf if negative, else 0x7BFF.
REQ-020 Underflow (rounded biased exp <= 0) SHALL return signed zero and set uf and nx.
REQ-021 nx SHALL be set whenever guard | sticky.
REQ-022 Special cases SHALL override the datapath result, with flags as listed:
- Any NaN operand: 0x7E00; nv set only if a NaN has frac[9]=0.
- 0/0 or inf/inf: 0x7E00, nv.
- finite nonzero / 0: signed inf, dz.
- inf/finite: signed inf, no flags.
- finite/inf and 0/nonzero: signed zero, no flags.
REQ-023 result and flags SHALL update only at the edge entering DONE.

Reset
REQ-024 reset_n low SHALL asynchronously force state IDLE, busy=0, done=0, result=0x0000, flags=0, and clear all operand/iteration registers.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no done pulse.
- After release, the next start SHALL be accepted normally.

Verification
REQ-026 Basic quotient: 0x4000 / 0x3C00, rne -> result 0x4000, flags 0, done exactly 15 edges after the accepting edge, busy high 14 cycles.
REQ-027 Inexact rounding: 0x3C00 / 0x4200 -> rne 0x3555, rz 0x3555, rp 0x3556, rn 0x3555; nx=1 in every mode.
REQ-028 Divide-by-zero and invalid: 0x3C00 / 0x0000 -> 0x7C00, dz; 0x8000 / 0x0000 -> 0x7E00, nv; 0x7C00 / 0xFC00 -> 0x7E00, nv.
REQ-029 Overflow: 0x7BFF / 0x3800 -> rne 0x7C00 with of+nx; rz 0x7BFF with of+nx.
- Underflow: 0x0400 / 0x7800 -> 0x0000 with uf+nx.
REQ-030 Control:
- start re-pulsed with new operands at cycles 3 and 10 of an operation SHALL not change that operation's result.
- reset_n pulsed low in ITER: busy=0 and result=0x0000 immediately, no done pulse; a following start completes correctly.

Source files
------------

// File: rtl/fdiv16_seq.sv
// fdiv16_seq: sequential IEEE-754 binary16 divider.
// Restoring division produces 13 quotient bits, one per ITER cycle. The
// result is then normalised and rounded to the selected mode during ROUND.
// Special operands are classified when the request is accepted. They override
// the datapath result at the end, so latency is the same for every operand.
//
// Handshake: a request is accepted on a rising edge where start=1 and the FSM
// is in IDLE; x/y/roundmode are captured on that edge only. busy is high while
// the operation is in ITER or ROUND. done pulses for exactly one cycle,
// 15 edges after the accepting edge. result/flags stay stable until the next
// done. Any start seen outside IDLE is dropped with no side effect.
module fdiv16_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        start,
  input  logic [1:0]  roundmode,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [4:0]  flags,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, ROUND = 2'd2, DONE = 2'd3} state_t;

  localparam logic [1:0] RM_RZ  = 2'b00;
  localparam logic [1:0] RM_RNE = 2'b01;
  localparam logic [1:0] RM_RP  = 2'b10;
  localparam logic [1:0] RM_RN  = 2'b11;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [11:0]        rem_q;
  logic [11:0]        my_q;
  logic [12:0]        quo_q;
  logic               sign_q;
  logic signed [7:0]  ediff_q;
  logic [1:0]         rm_q;
  logic               spec_q;
  logic [15:0]        spec_res_q;
  logic [4:0]         spec_flg_q;
  logic [15:0]        result_q, result_d;
  logic [4:0]         flags_q, flags_d;
  logic               done_q;

  logic               accept;
  assign accept = (state_q == IDLE) && start;

  // Operand unpacking; a zero exponent field is treated as zero, so subnormals flush.
  logic [4:0]  ex, ey;
  logic [9:0]  fx, fy;
  logic        zx, zy, ix, iy, nanx, nany, snanx, snany, sgn;
  logic [11:0] mx, my;
  logic signed [7:0] ediff;
  assign ex    = x[14:10];
  assign ey    = y[14:10];
  assign fx    = x[9:0];
  assign fy    = y[9:0];
  assign sgn   = x[15] ^ y[15];
  assign zx    = (ex == 5'd0);
  assign zy    = (ey == 5'd0);
  assign ix    = (ex == 5'd31) && (fx == 10'd0);
  assign iy    = (ey == 5'd31) && (fy == 10'd0);
  assign nanx  = (ex == 5'd31) && (fx != 10'd0);
  assign nany  = (ey == 5'd31) && (fy != 10'd0);
  assign snanx = nanx && !fx[9];
  assign snany = nany && !fy[9];
  assign mx    = zx ? 12'd0 : {2'b01, fx};
  assign my    = zy ? 12'd0 : {2'b01, fy};
  assign ediff = $signed({3'b000, ex}) - $signed({3'b000, ey});

  // Classify special operand combinations at accept time.
  logic        spec_d;
  logic [15:0] spec_res_d;
  logic [4:0]  spec_flg_d;
  always_comb begin
    spec_d     = 1'b1;
    spec_res_d = 16'h7E00;
    spec_flg_d = 5'b00000;
    if (nanx || nany) begin
      spec_flg_d = {(snanx || snany), 4'b0000};
    end else if ((zx && zy) || (ix && iy)) begin
      spec_flg_d = 5'b10000;
    end else if (ix) begin
      spec_res_d = {sgn, 15'h7C00};
    end else if (iy) begin
      spec_res_d = {sgn, 15'h0000};
    end else if (zy) begin
      spec_res_d = {sgn, 15'h7C00};
      spec_flg_d = 5'b01000;
    end else if (zx) begin
      spec_res_d = {sgn, 15'h0000};
    end else begin
      spec_d     = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: 13 ITER cycles, then one ROUND cycle and one DONE cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ITER;
          cnt_d   = 4'd0;
        end
      end
      ITER: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd12) state_d = ROUND;
      end
      ROUND:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Normalise, round and apply overflow/underflow/special overrides (used in ROUND).
  logic [9:0]        frac, frac_r;
  logic              guard, sticky, inc;
  logic [10:0]       msum;
  logic signed [7:0] be, be_r;
  always_comb begin
    frac     = 10'd0;
    guard    = 1'b0;
    sticky   = 1'b0;
    be       = 8'sd0;
    inc      = 1'b0;
    msum     = 11'd0;
    frac_r   = 10'd0;
    be_r     = 8'sd0;
    result_d = 16'h0000;
    flags_d  = 5'b00000;
    if (quo_q[12]) begin
      frac   = quo_q[11:2];
      guard  = quo_q[1];
      sticky = quo_q[0] | (rem_q != 12'd0);
      be     = ediff_q + 8'sd15;
    end else begin
      frac   = quo_q[10:1];
      guard  = quo_q[0];
      sticky = (rem_q != 12'd0);
      be     = ediff_q + 8'sd14;
    end
    unique case (rm_q)
      RM_RZ:   inc = 1'b0;
      RM_RNE:  inc = guard & (sticky | frac[0]);
      RM_RP:   inc = ~sign_q & (guard | sticky);
      RM_RN:   inc = sign_q & (guard | sticky);
      default: inc = 1'b0;
    endcase
    msum = {1'b0, frac} + {10'd0, inc};
    if (msum[10]) begin
      be_r   = be + 8'sd1;
      frac_r = 10'd0;
    end else begin
      be_r   = be;
      frac_r = msum[9:0];
    end
    if (be_r >= 8'sd31) begin
      flags_d = 5'b00101;
      unique case (rm_q)
        RM_RZ:   result_d = {sign_q, 15'h7BFF};
        RM_RNE:  result_d = {sign_q, 15'h7C00};
        RM_RP:   result_d = sign_q ? 16'hFBFF : 16'h7C00;
        RM_RN:   result_d = sign_q ? 16'hFC00 : 16'h7BFF;
        default: result_d = {sign_q, 15'h7C00};
      endcase
    end else if (be_r <= 8'sd0) begin
      flags_d  = 5'b00011;
      result_d = {sign_q, 15'h0000};
    end else begin
      flags_d  = {4'b0000, guard | sticky};
      result_d = {sign_q, be_r[4:0], frac_r};
    end
    if (spec_q) begin
      result_d = spec_res_q;
      flags_d  = spec_flg_q;
    end
  end

  // Operand capture, restoring iterations and result registration.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q      <= 12'd0;
      my_q       <= 12'd0;
      quo_q      <= 13'd0;
      sign_q     <= 1'b0;
      ediff_q    <= 8'sd0;
      rm_q       <= 2'b00;
      spec_q     <= 1'b0;
      spec_res_q <= 16'h0000;
      spec_flg_q <= 5'b00000;
      result_q   <= 16'h0000;
      flags_q    <= 5'b00000;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state_q == DONE);
      if (accept) begin
        rem_q      <= mx;
        my_q       <= my;
        quo_q      <= 13'd0;
        sign_q     <= sgn;
        ediff_q    <= ediff;
        rm_q       <= roundmode;
        spec_q     <= spec_d;
        spec_res_q <= spec_res_d;
        spec_flg_q <= spec_flg_d;
      end else if (state_q == ITER) begin
        if (rem_q >= my_q) begin
          rem_q <= (rem_q - my_q) << 1;
          quo_q <= {quo_q[11:0], 1'b1};
        end else begin
          rem_q <= rem_q << 1;
          quo_q <= {quo_q[11:0], 1'b0};
        end
      end else if (state_q == ROUND) begin
        result_q <= result_d;
        flags_q  <= flags_d;
      end
    end
  end

  assign busy        = (state_q == ITER) || (state_q == ROUND);
  assign done        = done_q;
  assign result      = result_q;
  assign flags       = flags_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fdiv16_seq.sv
// tb_fdiv16_seq: directed vectors with hand-computed fp16 quotients and flags.
module tb_fdiv16_seq;

  logic        clk;
  logic        reset_n;
  logic [15:0] x, y;
  logic        start;
  logic [1:0]  roundmode;
  logic        busy, done;
  logic [15:0] result;
  logic [4:0]  flags;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  fdiv16_seq dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .x           (x),
    .y           (y),
    .start       (start),
    .roundmode   (roundmode),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .flags       (flags),
    .dbg_state_o (dbg_state)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation: drive the request, track busy/done, then check the outcome.
  // With glitch set, start is re-pulsed with random operands at cycles 3 and 10.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] rm, input logic [15:0] exp_r,
                        input logic [4:0] exp_f, input bit glitch);
    int edges;
    int busy_cnt;
    @(negedge clk);
    x = a; y = b; roundmode = rm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x = 16'($urandom); y = 16'($urandom); roundmode = 2'($urandom_range(0, 3));
    edges = 0;
    busy_cnt = 0;
    while (!done && edges < 40) begin
      if (busy) busy_cnt++;
      start = glitch && (edges == 3 || edges == 10);
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    check({tag, ".done_seen"}, done, 1'b1);
    check({tag, ".latency"}, edges, 15);
    check({tag, ".busy_cycles"}, busy_cnt, 14);
    check({tag, ".result"}, result, exp_r);
    check({tag, ".flags"}, flags, exp_f);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, done, 1'b0);
    check({tag, ".held"}, result, exp_r);
  endtask

  initial begin
    int done_seen;
    reset_n = 1'b0; x = 16'h0; y = 16'h0; start = 1'b0; roundmode = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", busy, 1'b0);
    check("rst.done", done, 1'b0);
    check("rst.result", result, 16'h0000);
    check("rst.flags", flags, 5'b00000);
    check("rst.state", dbg_state, 2'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Flags are {nv, dz, of, uf, nx}.
    run_op("basic",      16'h4000, 16'h3C00, 2'b01, 16'h4000, 5'b00000, 1'b0);
    run_op("third_rne",  16'h3C00, 16'h4200, 2'b01, 16'h3555, 5'b00001, 1'b0);
    run_op("third_rz",   16'h3C00, 16'h4200, 2'b00, 16'h3555, 5'b00001, 1'b0);
    run_op("third_rp",   16'h3C00, 16'h4200, 2'b10, 16'h3556, 5'b00001, 1'b0);
    run_op("third_rn",   16'h3C00, 16'h4200, 2'b11, 16'h3555, 5'b00001, 1'b0);
    run_op("nthird_rn",  16'hBC00, 16'h4200, 2'b11, 16'hB556, 5'b00001, 1'b0);
    run_op("nthird_rp",  16'hBC00, 16'h4200, 2'b10, 16'hB555, 5'b00001, 1'b0);
    run_op("div_zero",   16'h3C00, 16'h0000, 2'b01, 16'h7C00, 5'b01000, 1'b0);
    run_op("zero_zero",  16'h8000, 16'h0000, 2'b01, 16'h7E00, 5'b10000, 1'b0);
    run_op("inf_inf",    16'h7C00, 16'hFC00, 2'b01, 16'h7E00, 5'b10000, 1'b0);
    run_op("qnan",       16'h7E00, 16'h3C00, 2'b01, 16'h7E00, 5'b00000, 1'b0);
    run_op("snan",       16'h3C00, 16'h7D00, 2'b00, 16'h7E00, 5'b10000, 1'b0);
    run_op("inf_fin",    16'hFC00, 16'h4000, 2'b01, 16'hFC00, 5'b00000, 1'b0);
    run_op("fin_inf",    16'h4000, 16'hFC00, 2'b01, 16'h8000, 5'b00000, 1'b0);
    run_op("zero_fin",   16'h8000, 16'h3C00, 2'b01, 16'h8000, 5'b00000, 1'b0);
    run_op("ovf_rne",    16'h7BFF, 16'h3800, 2'b01, 16'h7C00, 5'b00101, 1'b0);
    run_op("ovf_rz",     16'h7BFF, 16'h3800, 2'b00, 16'h7BFF, 5'b00101, 1'b0);
    run_op("novf_rp",    16'hFBFF, 16'h3800, 2'b10, 16'hFBFF, 5'b00101, 1'b0);
    run_op("novf_rn",    16'hFBFF, 16'h3800, 2'b11, 16'hFC00, 5'b00101, 1'b0);
    run_op("unf",        16'h0400, 16'h7800, 2'b01, 16'h0000, 5'b00011, 1'b0);
    run_op("glitch",     16'h3C00, 16'h4200, 2'b10, 16'h3556, 5'b00001, 1'b1);

    // Leave a nonzero result behind, then reset in the middle of ITER.
    run_op("pre_rst",    16'h4000, 16'h3C00, 2'b01, 16'h4000, 5'b00000, 1'b0);
    @(negedge clk);
    x = 16'h3C00; y = 16'h4200; roundmode = 2'b10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst.busy", busy, 1'b0);
    check("mid_rst.result", result, 16'h0000);
    check("mid_rst.flags", flags, 5'b00000);
    check("mid_rst.state", dbg_state, 2'd0);
    done_seen = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check("mid_rst.no_done", done_seen, 0);
    run_op("post_rst",   16'h3C00, 16'h4200, 2'b10, 16'h3556, 5'b00001, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
